csr_asid: RTL
=============

# csr_asid

Parametrised LoongArch32 ASID control/status register, sitting in the CSR file next to the TLB. Holds the current address-space identifier with masked CSR writes and TLBRD writes. ASIDBITS is read-only and derived from the configured width. Every effective ASID change is reported to the TLB/MMU through a valid/ready notification channel that coalesces back-to-back changes.

## Interface
- ASID_W, 10, implemented ASID width, legal 1..16; also the value reported in ASIDBITS
- DATA_W, 32, CSR data width; fixed at 32
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- csr_we  in  1  CSR write strobe (csrwr/csrxchg commit)
- csr_wmask  in  32  per-bit write mask (all-ones for csrwr)
- csr_wdata  in  32  CSR write data
- csr_wr_ready  out  1  write accepted this cycle
- tlbrd_we  in  1  TLBRD commit updates ASID field
- tlbrd_asid  in  ASID_W  ASID read from TLB entry
- csr_rdata  out  32  register image, combinational from state
- asid  out  ASID_W  current ASID to TLB lookup
- chg_valid  out  1  ASID change pending
- chg_ready  in  1  consumer accepts change
- chg_old_asid  out  ASID_W  ASID before first unreported change
- chg_new_asid  out  ASID_W  latest ASID

## Operation
- Layout of csr_rdata:
  - [ASID_W-1:0] ASID, read/write.
  - [23:16] ASIDBITS = ASID_W, read-only.
  - All other bits read as 0; writes to them are ignored.
- CSR write: next = (asid & ~m) | (wdata & m), where m = csr_wmask[ASID_W-1:0].
- TLBRD write: next = tlbrd_asid.
- csr_we and tlbrd_we in the same cycle: the CSR write wins and the TLBRD update is dropped.
- An accepted write whose next equals the current asid updates nothing and raises no notification.
- FSM IDLE/PEND:
  - IDLE → PEND on an effective change: chg_old_asid = old asid, chg_new_asid = next.
  - PEND, chg_ready=1, no new change → IDLE.
  - PEND, new change, chg_ready=0 → stay in PEND. chg_new_asid = next; chg_old_asid is unchanged (coalesce).
  - PEND, new change, chg_ready=1 → stay in PEND. chg_old_asid = previous chg_new_asid; chg_new_asid = next.
  - A coalesced change back to the original value is still reported (old==new allowed).
- Reset values: asid = 0; csr_rdata = ASID_W<<16 (0x000A0000 at default); chg_valid = 0; chg_old_asid = chg_new_asid = 0; FSM in IDLE; csr_wr_ready = 1.

## Timing
- Write latency 1: the write in cycle N is visible on asid/csr_rdata in cycle N+1. chg_valid also rises in N+1.
- chg_valid, chg_old_asid and chg_new_asid are registered.
  - They stay stable while chg_valid=1 and chg_ready=0, except for coalescing on a new change.
- Handshake completes on the edge where chg_valid & chg_ready are both 1.
- chg_ready has no effect while idle.
- rst_n assertion mid-PEND: chg_valid drops immediately (asynchronously) and the pending change is discarded.

## Configuration
- CSR_ASID_WR_STALL_EN defined:
  - csr_wr_ready = (state == IDLE), or (PEND and chg_ready=1).
  - csr_we and tlbrd_we are ignored while not ready; the producer holds them. Coalescing never occurs.
- Undefined: csr_wr_ready is tied to 1 and coalescing applies.

## Structure
- Shared package csr_pkg holds:
  - CSR_ASID_ADDR = 14'h18, ASID_ASIDBITS_LSB = 16, ASID_ASIDBITS_W = 8.
  - The typedef for the notify FSM state enum.
- One sub-module: asid_chg_notify, the valid/ready holding register with coalesce logic, parametrised by ASID_W.

## Test plan
- Reset with ASID_W=10 → csr_rdata=0x000A0000, asid=0, chg_valid=0.
- csr_we, wmask=0xFFFFFFFF, wdata=0xFFFF_F3A5 → next cycle csr_rdata=0x000A03A5.
  - chg_valid=1, old=0x000, new=0x3A5.
- chg_ready low 3 cycles, then high → outputs stable throughout; chg_valid falls after the accept edge.
  - A rewrite of 0x3A5 → no new chg_valid.
- While pending (old=0, new=0x3A5), tlbrd_we with tlbrd_asid=0x011 → new=0x011, old stays 0.
  - Simultaneous csr_we 0x022 + tlbrd 0x033 → asid=0x022.
- With wmask=0x0000000F, wdata=0x6 on asid=0x3A5 → asid=0x3A6; ASIDBITS unchanged.
- With CSR_ASID_WR_STALL_EN, a write held during PEND with chg_ready=0 → csr_wr_ready=0 and asid unchanged.
  - It is accepted in the chg_ready cycle; a fresh notification follows with old=previous new.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR-file definitions: ASID CSR address, ASIDBITS field placement and
// the change-notification FSM state type.
package csr_pkg;

    localparam logic [13:0] CSR_ASID_ADDR     = 14'h18;
    localparam int          ASID_ASIDBITS_LSB = 16;
    localparam int          ASID_ASIDBITS_W   = 8;

    typedef enum logic {
        CHG_IDLE = 1'b0,
        CHG_PEND = 1'b1
    } chg_state_e;

endpackage

// File: rtl/asid_chg_notify.sv
// Valid/ready holding register for ASID change notifications; back-to-back
// changes while a notification is outstanding are merged into one.
module asid_chg_notify
    import csr_pkg::*;
#(
    parameter int ASID_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chg_in,
    input  logic [ASID_W-1:0] old_in,
    input  logic [ASID_W-1:0] new_in,
    input  logic              chg_ready,
    output logic              chg_valid,
    output logic [ASID_W-1:0] chg_old_asid,
    output logic [ASID_W-1:0] chg_new_asid
);

    chg_state_e        state_q, state_d;
    logic [ASID_W-1:0] old_q, old_d;
    logic [ASID_W-1:0] new_q, new_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CHG_IDLE;
            old_q   <= '0;
            new_q   <= '0;
        end else begin
            state_q <= state_d;
            old_q   <= old_d;
            new_q   <= new_d;
        end
    end

    always_comb begin
        state_d = state_q;
        old_d   = old_q;
        new_d   = new_q;
        case (state_q)
            CHG_IDLE: begin
                if (chg_in) begin
                    state_d = CHG_PEND;
                    old_d   = old_in;
                    new_d   = new_in;
                end
            end
            CHG_PEND: begin
                if (chg_in) begin
                    // Accepted notification retires; the new one starts from what was reported.
                    if (chg_ready) begin
                        old_d = new_q;
                    end
                    new_d = new_in;
                end else if (chg_ready) begin
                    state_d = CHG_IDLE;
                end
            end
            default: state_d = CHG_IDLE;
        endcase
    end

    assign chg_valid    = (state_q == CHG_PEND);
    assign chg_old_asid = old_q;
    assign chg_new_asid = new_q;

endmodule

// File: rtl/csr_asid.sv
// LoongArch32 ASID CSR with masked CSR writes, TLBRD updates and change notify.
// Define CSR_ASID_WR_STALL_EN to back-pressure writes while a change is unacknowledged.
module csr_asid
    import csr_pkg::*;
#(
    parameter int ASID_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_we,
    input  logic [DATA_W-1:0] csr_wmask,
    input  logic [DATA_W-1:0] csr_wdata,
    output logic              csr_wr_ready,
    input  logic              tlbrd_we,
    input  logic [ASID_W-1:0] tlbrd_asid,
    output logic [DATA_W-1:0] csr_rdata,
    output logic [ASID_W-1:0] asid,
    output logic              chg_valid,
    input  logic              chg_ready,
    output logic [ASID_W-1:0] chg_old_asid,
    output logic [ASID_W-1:0] chg_new_asid
);

    logic [ASID_W-1:0] asid_q;
    logic [ASID_W-1:0] asid_next;
    logic [ASID_W-1:0] wmask;
    logic              csr_fire;
    logic              tlbrd_fire;
    logic              asid_chg;

`ifdef CSR_ASID_WR_STALL_EN
    assign csr_wr_ready = ~chg_valid | chg_ready;
`else
    assign csr_wr_ready = 1'b1;
`endif

    // CSR write has priority; a simultaneous TLBRD update is dropped.
    assign wmask      = csr_wmask[ASID_W-1:0];
    assign csr_fire   = csr_we & csr_wr_ready;
    assign tlbrd_fire = tlbrd_we & csr_wr_ready & ~csr_we;

    always_comb begin
        asid_next = asid_q;
        if (csr_fire) begin
            asid_next = (asid_q & ~wmask) | (csr_wdata[ASID_W-1:0] & wmask);
        end else if (tlbrd_fire) begin
            asid_next = tlbrd_asid;
        end
    end

    assign asid_chg = (asid_next != asid_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asid_q <= '0;
        end else if (asid_chg) begin
            asid_q <= asid_next;
        end
    end

    always_comb begin
        csr_rdata = '0;
        csr_rdata[ASID_W-1:0] = asid_q;
        csr_rdata[ASID_ASIDBITS_LSB +: ASID_ASIDBITS_W] = ASID_ASIDBITS_W'(ASID_W);
    end

    assign asid = asid_q;

    asid_chg_notify #(
        .ASID_W(ASID_W)
    ) u_notify (
        .clk          (clk),
        .rst_n        (rst_n),
        .chg_in       (asid_chg),
        .old_in       (asid_q),
        .new_in       (asid_next),
        .chg_ready    (chg_ready),
        .chg_valid    (chg_valid),
        .chg_old_asid (chg_old_asid),
        .chg_new_asid (chg_new_asid)
    );

endmodule
